// File: rtl/trigger_rate_scaler.sv
// trigger_rate_scaler: per-beam gated trigger counter with holdoff, saturation and a latched result bank
module trigger_rate_scaler #(
  parameter int NBEAMS = 2,
  parameter int COUNT_WIDTH = 32,
  parameter int PERIOD_WIDTH = 32,
  parameter int HOLDOFF_WIDTH = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [NBEAMS-1:0] trig_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
  input  logic continuous_i,
  input  logic start_i,
  input  logic stop_i,
  input  logic [$clog2(NBEAMS > 1 ? NBEAMS : 2)-1:0] rd_idx_i,
  output logic [COUNT_WIDTH-1:0] rd_dat_o,
  output logic rd_sat_o,
  output logic busy_o,
  output logic done_o,
  output logic [15:0] seq_o
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state;
  logic [PERIOD_WIDTH-1:0] period, gate;
  logic [HOLDOFF_WIDTH-1:0] hold;
  logic cont, term, rd_ok;
  logic [COUNT_WIDTH-1:0] count [NBEAMS];
  logic [COUNT_WIDTH-1:0] count_nx [NBEAMS];
  logic [COUNT_WIDTH-1:0] result [NBEAMS];
  logic [HOLDOFF_WIDTH-1:0] holdoff [NBEAMS];
  logic [HOLDOFF_WIDTH-1:0] ho_nx [NBEAMS];
  logic [NBEAMS-1:0] sat, sat_nx, res_sat, hit;
  for (genvar g = 0; g < NBEAMS; g++) begin : g_beam
    assign hit[g] = trig_i[g] && holdoff[g] == '0;
    assign count_nx[g] = hit[g] && count[g] != '1 ? count[g] + COUNT_WIDTH'(1) : count[g];
    assign sat_nx[g] = sat[g] | (hit[g] && count[g] == '1);
    assign ho_nx[g] = hit[g] ? hold : holdoff[g] != '0 ? holdoff[g] - HOLDOFF_WIDTH'(1) : '0;
  end
  assign term = gate == period - PERIOD_WIDTH'(1);
  assign rd_ok = 32'(rd_idx_i) < NBEAMS;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      period <= '0;
      gate <= '0;
      hold <= '0;
      cont <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      seq_o <= '0;
      sat <= '0;
      res_sat <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        count[b] <= '0;
        result[b] <= '0;
        holdoff[b] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      if (state == IDLE) begin
        if (start_i && !stop_i) begin
          state <= COUNT;
          busy_o <= 1'b1;
          period <= period_i == '0 ? PERIOD_WIDTH'(1) : period_i;
          hold <= holdoff_i;
          cont <= continuous_i;
          gate <= '0;
          sat <= '0;
          for (int b = 0; b < NBEAMS; b++) begin
            count[b] <= '0;
            holdoff[b] <= '0;
          end
        end
      end else if (stop_i) begin
        state <= IDLE;
        busy_o <= 1'b0;
      end else begin
        for (int b = 0; b < NBEAMS; b++) holdoff[b] <= ho_nx[b];
        if (term) begin
          for (int b = 0; b < NBEAMS; b++) result[b] <= count_nx[b];
          res_sat <= sat_nx;
          seq_o <= seq_o + 16'd1;
          done_o <= 1'b1;
          gate <= '0;
          sat <= '0;
          for (int b = 0; b < NBEAMS; b++) count[b] <= '0;
          if (!cont) begin
            state <= IDLE;
            busy_o <= 1'b0;
          end
        end else begin
          gate <= gate + PERIOD_WIDTH'(1);
          sat <= sat_nx;
          for (int b = 0; b < NBEAMS; b++) count[b] <= count_nx[b];
        end
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_dat_o <= '0;
      rd_sat_o <= 1'b0;
    end else begin
      rd_dat_o <= rd_ok ? result[rd_idx_i] : '0;
      rd_sat_o <= rd_ok ? res_sat[rd_idx_i] : 1'b0;
    end
  end
endmodule

// File: tb/tb_trigger_rate_scaler.sv
// tb_trigger_rate_scaler: directed runs with a done-driven scoreboard for the scaler
module tb_trigger_rate_scaler;
  logic clk = 0, rst = 1, continuous = 0, start = 0, start4 = 0, stop = 0;
  logic [1:0] trig = 0;
  logic [31:0] period = 0;
  logic [4:0] holdoff = 0;
  logic rd_idx = 0, rd_idx4 = 0;
  logic [31:0] rd_dat;
  logic [3:0] rd_dat4;
  logic rd_sat, busy, done, rd_sat4, busy4, done4;
  logic [15:0] seq, seq4;
  int cyc = 0, tests = 0, fails = 0, t0;
  typedef struct {int cyc; int r0; int s0; int r1; int s1; int seq; int busy;} exp_t;
  typedef struct {int cyc; int r; int s;} exp4_t;
  exp_t q[$];
  exp4_t q4[$];

  trigger_rate_scaler dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .period_i(period), .holdoff_i(holdoff),
    .continuous_i(continuous), .start_i(start), .stop_i(stop), .rd_idx_i(rd_idx),
    .rd_dat_o(rd_dat), .rd_sat_o(rd_sat), .busy_o(busy), .done_o(done), .seq_o(seq));
  trigger_rate_scaler #(.COUNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .period_i(period), .holdoff_i(holdoff),
    .continuous_i(continuous), .start_i(start4), .stop_i(stop), .rd_idx_i(rd_idx4),
    .rd_dat_o(rd_dat4), .rd_sat_o(rd_sat4), .busy_o(busy4), .done_o(done4), .seq_o(seq4));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(string n, longint a, longint e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic go(int p, int h, bit c, bit use4, output int t);
    period = p;
    holdoff = 5'(h);
    continuous = c;
    if (use4) start4 = 1; else start = 1;
    t = cyc;
    @(negedge clk);
    start = 0;
    start4 = 0;
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("seq", seq, e.seq);
          chk("busy_at_done", busy, e.busy);
          rd_idx = 0;
          @(negedge clk);
          chk("done_pulse_width", done, 0);
          chk("result0", rd_dat, e.r0);
          chk("sat0", rd_sat, e.s0);
          rd_idx = 1;
          @(negedge clk);
          chk("result1", rd_dat, e.r1);
          chk("sat1", rd_sat, e.s1);
          rd_idx = 0;
        end
      end
    end
  end

  initial begin
    exp4_t e;
    forever begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        if (q4.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done4: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q4.pop_front();
          chk("w4_done_cycle", cyc, e.cyc);
          @(negedge clk);
          chk("w4_result", rd_dat4, e.r);
          chk("w4_sat", rd_sat4, e.s);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seq", seq, 0);
    chk("rst_rd_dat", rd_dat, 0);
    chk("rst_rd_sat", rd_sat, 0);
    rst = 0;
    @(negedge clk);
    trig = 2'b01;
    go(10, 3, 0, 0, t0);
    q.push_back('{t0 + 11, 3, 0, 0, 0, 1, 0});
    wait_cyc(t0 + 16);
    trig = 2'b11;
    go(10, 0, 0, 0, t0);
    q.push_back('{t0 + 11, 10, 0, 10, 0, 2, 0});
    wait_cyc(t0 + 16);
    trig = 2'b01;
    go(0, 0, 0, 0, t0);
    q.push_back('{t0 + 2, 1, 0, 0, 0, 3, 0});
    wait_cyc(t0 + 6);
    trig = 2'b10;
    go(6, 1, 0, 0, t0);
    q.push_back('{t0 + 7, 0, 0, 3, 0, 4, 0});
    wait_cyc(t0 + 12);
    trig = 2'b01;
    go(8, 0, 1, 0, t0);
    q.push_back('{t0 + 9, 8, 0, 0, 0, 5, 1});
    q.push_back('{t0 + 17, 8, 0, 0, 0, 6, 1});
    q.push_back('{t0 + 25, 8, 0, 0, 0, 7, 1});
    wait_cyc(t0 + 25);
    trig = 2'b00;
    wait_cyc(t0 + 27);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("cont_stop_busy", busy, 0);
    wait_cyc(t0 + 34);
    chk("cont_stop_seq", seq, 7);
    trig = 2'b01;
    go(10, 0, 0, 0, t0);
    wait_cyc(t0 + 5);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("stop_busy", busy, 0);
    wait_cyc(t0 + 14);
    chk("stop_seq", seq, 7);
    chk("stop_result", rd_dat, 8);
    go(10, 0, 0, 0, t0);
    wait_cyc(t0 + 10);
    chk("term_busy_before_stop", busy, 1);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("term_stop_busy", busy, 0);
    wait_cyc(t0 + 14);
    chk("term_stop_seq", seq, 7);
    chk("term_stop_result", rd_dat, 8);
    go(10, 0, 0, 0, t0);
    q.push_back('{t0 + 11, 10, 0, 0, 0, 8, 0});
    wait_cyc(t0 + 5);
    period = 3;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_cyc(t0 + 16);
    trig = 2'b01;
    go(20, 0, 0, 1, t0);
    q4.push_back('{t0 + 21, 15, 1});
    wait_cyc(t0 + 25);
    trig = 2'b00;
    go(20, 0, 0, 1, t0);
    q4.push_back('{t0 + 21, 0, 0});
    wait_cyc(t0 + 25);
    trig = 2'b01;
    go(8, 0, 1, 0, t0);
    wait_cyc(t0 + 4);
    chk("pre_rst_rd_dat", rd_dat, 10);
    rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_seq", seq, 0);
    chk("arst_rd_dat", rd_dat, 0);
    chk("arst_rd_sat", rd_sat, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    go(4, 0, 0, 0, t0);
    q.push_back('{t0 + 5, 4, 0, 0, 0, 1, 0});
    wait_cyc(t0 + 10);
    chk("queue_drained", q.size(), 0);
    chk("queue4_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
